// File: rtl/fila_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fila_pkg
// Description : Shared constants and FSM encoding for the fila queue controller.
// Revision    : 1.0 - initial release
// ============================================================================
package fila_pkg;

    localparam int FILA_DEPTH  = 8;
    localparam int DEQ_LATENCY = 2;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ENQ  = 3'd1,
        DEQ  = 3'd2,
        WAIT = 3'd3,
        CAPT = 3'd4
    } ctrl_state_t;

endpackage
`default_nettype wire

// File: rtl/fila_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : fila_ctrl_if
// Description : Button, switch and queue-facing signals of the fila controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface fila_ctrl_if;

    logic       btn_enq_in;
    logic       btn_deq_in;
    logic [7:0] sw_data_in;
    logic [7:0] len_in;
    logic [7:0] fila_data_in;
    logic       enqueue_out;
    logic       dequeue_out;
    logic [7:0] data_out;
    logic [7:0] last_out;
    logic       last_valid_out;
    logic       err_full_out;
    logic       err_empty_out;

    modport master (
        input  btn_enq_in, btn_deq_in, sw_data_in, len_in, fila_data_in,
        output enqueue_out, dequeue_out, data_out, last_out, last_valid_out,
               err_full_out, err_empty_out
    );

    modport slave (
        output btn_enq_in, btn_deq_in, sw_data_in, len_in, fila_data_in,
        input  enqueue_out, dequeue_out, data_out, last_out, last_valid_out,
               err_full_out, err_empty_out
    );

endinterface
`default_nettype wire

// File: rtl/fila_ctrl_debouncer.sv
`default_nettype none
// ============================================================================
// Module      : debouncer
// Description : 2-flop synchronizer plus stable-count debouncer for one button.
// Revision    : 1.0 - initial release
// ============================================================================
module debouncer #(
    parameter int DEBOUNCE_CYCLES = 200
) (
    input  wire logic clock_10KHz,
    input  wire logic reset,
    input  wire logic btn_in,
    output logic      level_out
);

    localparam int            c_cnt_w = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(DEBOUNCE_CYCLES - 1);

    logic [1:0]         r_sync;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_level;

    // Level flips on the DEBOUNCE_CYCLES-th consecutive differing sample; any agreement restarts the count.
    always_ff @(posedge clock_10KHz or posedge reset) begin
        if (reset) begin
            r_sync  <= 2'b00;
            r_cnt   <= '0;
            r_level <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], btn_in};
            if (r_sync[1] == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == c_last) begin
                r_level <= r_sync[1];
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign level_out = r_level;

endmodule
`default_nettype wire

// File: rtl/fila_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fila_ctrl
// Description : Button front-end for the fila byte queue: edge detect, command
//               FSM, full/empty error flags and dequeued-byte capture.
//               FILA_CTRL_DEBOUNCE_EN selects debounced buttons (else sync only).
// Revision    : 1.0 - initial release
// ============================================================================
module fila_ctrl #(
    parameter int DEBOUNCE_CYCLES = 200,
    parameter int FILA_DEPTH      = fila_pkg::FILA_DEPTH
) (
    input  wire logic   clock_10KHz,
    input  wire logic   reset,
    fila_ctrl_if.master bus
);

    import fila_pkg::*;

    localparam logic [2:0] c_st_idle = IDLE;
    localparam logic [2:0] c_st_enq  = ENQ;
    localparam logic [2:0] c_st_deq  = DEQ;
    localparam logic [2:0] c_st_wait = WAIT;
    localparam logic [2:0] c_st_capt = CAPT;
    localparam logic [7:0] c_depth   = 8'(FILA_DEPTH);
    localparam logic       c_capt_end = 1'(DEQ_LATENCY - 1);

    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("fila_ctrl: DEBOUNCE_CYCLES must be at least 1");
    end

    logic w_enq_level;
    logic w_deq_level;

`ifdef FILA_CTRL_DEBOUNCE_EN
    debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dbnc_enq (
        .clock_10KHz (clock_10KHz),
        .reset       (reset),
        .btn_in      (bus.btn_enq_in),
        .level_out   (w_enq_level)
    );

    debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dbnc_deq (
        .clock_10KHz (clock_10KHz),
        .reset       (reset),
        .btn_in      (bus.btn_deq_in),
        .level_out   (w_deq_level)
    );
`else
    logic [1:0] r_sync_enq;
    logic [1:0] r_sync_deq;

    always_ff @(posedge clock_10KHz or posedge reset) begin
        if (reset) begin
            r_sync_enq <= 2'b00;
            r_sync_deq <= 2'b00;
        end else begin
            r_sync_enq <= {r_sync_enq[0], bus.btn_enq_in};
            r_sync_deq <= {r_sync_deq[0], bus.btn_deq_in};
        end
    end

    assign w_enq_level = r_sync_enq[1];
    assign w_deq_level = r_sync_deq[1];
`endif

    logic       r_enq_prev, r_deq_prev;
    logic       r_enq_req,  r_deq_req;
    logic [2:0] r_state;
    logic       r_capt_cnt;
    logic       r_enqueue, r_dequeue;
    logic [7:0] r_data;
    logic [7:0] r_last;
    logic       r_last_valid;
    logic       r_err_full, r_err_empty;

    always_ff @(posedge clock_10KHz or posedge reset) begin
        if (reset) begin
            r_enq_prev <= 1'b0;
            r_deq_prev <= 1'b0;
            r_enq_req  <= 1'b0;
            r_deq_req  <= 1'b0;
        end else begin
            r_enq_prev <= w_enq_level;
            r_deq_prev <= w_deq_level;
            r_enq_req  <= w_enq_level & ~r_enq_prev;
            r_deq_req  <= w_deq_level & ~r_deq_prev;
        end
    end

    // Requests are only looked at in IDLE, so anything arriving mid-command is dropped.
    always_ff @(posedge clock_10KHz or posedge reset) begin
        if (reset) begin
            r_state      <= c_st_idle;
            r_capt_cnt   <= 1'b0;
            r_enqueue    <= 1'b0;
            r_dequeue    <= 1'b0;
            r_data       <= 8'h00;
            r_last       <= 8'h00;
            r_last_valid <= 1'b0;
            r_err_full   <= 1'b0;
            r_err_empty  <= 1'b0;
        end else begin
            r_enqueue <= 1'b0;
            r_dequeue <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (r_enq_req) begin
                        if (bus.len_in < c_depth) begin
                            r_data      <= bus.sw_data_in;
                            r_err_full  <= 1'b0;
                            r_err_empty <= 1'b0;
                            r_enqueue   <= 1'b1;
                            r_state     <= c_st_enq;
                        end else begin
                            r_err_full  <= 1'b1;
                            r_err_empty <= 1'b0;
                        end
                    end else if (r_deq_req) begin
                        if (bus.len_in != 8'd0) begin
                            r_err_full  <= 1'b0;
                            r_err_empty <= 1'b0;
                            r_dequeue   <= 1'b1;
                            r_state     <= c_st_deq;
                        end else begin
                            r_err_empty <= 1'b1;
                            r_err_full  <= 1'b0;
                        end
                    end
                end
                c_st_enq:  r_state <= c_st_wait;
                c_st_wait: r_state <= c_st_idle;
                c_st_deq: begin
                    r_capt_cnt <= 1'b0;
                    r_state    <= c_st_capt;
                end
                c_st_capt: begin
                    // The queue presents the popped byte for exactly one cycle, DEQ_LATENCY after the pulse.
                    if (r_capt_cnt == c_capt_end) begin
                        r_last       <= bus.fila_data_in;
                        r_last_valid <= 1'b1;
                        r_state      <= c_st_idle;
                    end else begin
                        r_capt_cnt <= r_capt_cnt + 1'b1;
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    assign bus.enqueue_out    = r_enqueue;
    assign bus.dequeue_out    = r_dequeue;
    assign bus.data_out       = r_data;
    assign bus.last_out       = r_last;
    assign bus.last_valid_out = r_last_valid;
    assign bus.err_full_out   = r_err_full;
    assign bus.err_empty_out  = r_err_empty;

endmodule
`default_nettype wire

// File: tb/tb_fila_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fila_ctrl
// Description : Self-checking bench for fila_ctrl with a behavioural fila queue
//               and a queue-based reference model; bounce step needs FILA_CTRL_DEBOUNCE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fila_ctrl;

    localparam int DEPTH  = 8;
    localparam int HOLD   = 14;
    localparam int SETTLE = 14;

    logic clock_10KHz = 1'b0;
    logic reset       = 1'b1;

    fila_ctrl_if bus ();

    fila_ctrl #(.DEBOUNCE_CYCLES(4), .FILA_DEPTH(DEPTH)) dut (
        .clock_10KHz (clock_10KHz),
        .reset       (reset),
        .bus         (bus.master)
    );

    always #5 clock_10KHz = ~clock_10KHz;

    // Stand-in for the fila queue: writes one cycle after the enqueue pulse,
    // presents the popped byte in the second cycle after the dequeue pulse.
    logic [7:0] mem [DEPTH];
    int         head, tail;
    logic       enq_d, deq_d;

    always @(posedge clock_10KHz or posedge reset) begin
        if (reset) begin
            head             <= 0;
            tail             <= 0;
            enq_d            <= 1'b0;
            deq_d            <= 1'b0;
            bus.len_in       <= 8'd0;
            bus.fila_data_in <= 8'hA5;
        end else begin
            enq_d            <= bus.enqueue_out;
            deq_d            <= bus.dequeue_out;
            bus.fila_data_in <= 8'($urandom);
            if (enq_d && bus.len_in < DEPTH) begin
                mem[tail]  <= bus.data_out;
                tail       <= (tail + 1) % DEPTH;
                bus.len_in <= bus.len_in + 8'd1;
            end else if (deq_d && bus.len_in > 0) begin
                bus.fila_data_in <= mem[head];
                head             <= (head + 1) % DEPTH;
                bus.len_in       <= bus.len_in - 8'd1;
            end
        end
    end

    int n_enq = 0;
    int n_deq = 0;

    always @(negedge clock_10KHz) begin
        if (bus.enqueue_out) n_enq <= n_enq + 1;
        if (bus.dequeue_out) n_deq <= n_deq + 1;
    end

    int         errors = 0;
    int         checks = 0;
    logic [7:0] exp_q [$];
    logic [7:0] exp_data  = 8'h00;
    logic [7:0] exp_last  = 8'h00;
    logic       exp_valid = 1'b0;
    logic       exp_full  = 1'b0;
    logic       exp_empty = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, want);
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, ".data_out"},   32'(bus.data_out),       32'(exp_data));
        check({tag, ".last_out"},   32'(bus.last_out),       32'(exp_last));
        check({tag, ".last_valid"}, 32'(bus.last_valid_out), 32'(exp_valid));
        check({tag, ".err_full"},   32'(bus.err_full_out),   32'(exp_full));
        check({tag, ".err_empty"},  32'(bus.err_empty_out),  32'(exp_empty));
        check({tag, ".len"},        32'(bus.len_in),         32'(exp_q.size()));
    endtask

    task automatic press(input logic e, input logic d, input logic [7:0] sw);
        bus.sw_data_in = sw;
        bus.btn_enq_in = e;
        bus.btn_deq_in = d;
        repeat (HOLD) @(negedge clock_10KHz);
        bus.btn_enq_in = 1'b0;
        bus.btn_deq_in = 1'b0;
        repeat (SETTLE) @(negedge clock_10KHz);
    endtask

    // Reference: an enqueue press beats a dequeue press; full/empty reject and flag.
    task automatic do_op(input string tag, input logic e, input logic d, input logic [7:0] sw);
        int e0, d0, want_e, want_d;
        e0 = n_enq;
        d0 = n_deq;
        want_e = 0;
        want_d = 0;
        if (e) begin
            if (exp_q.size() < DEPTH) begin
                exp_q.push_back(sw);
                exp_data  = sw;
                want_e    = 1;
                exp_full  = 1'b0;
            end else begin
                exp_full  = 1'b1;
            end
            exp_empty = 1'b0;
        end else if (d) begin
            if (exp_q.size() > 0) begin
                exp_last  = exp_q.pop_front();
                exp_valid = 1'b1;
                want_d    = 1;
                exp_empty = 1'b0;
            end else begin
                exp_empty = 1'b1;
            end
            exp_full = 1'b0;
        end
        press(e, d, sw);
        check({tag, ".enq_pulses"}, 32'(n_enq - e0), 32'(want_e));
        check({tag, ".deq_pulses"}, 32'(n_deq - d0), 32'(want_d));
        check_state(tag);
    endtask

    initial begin
        int   e0, d0;
        logic found;

        bus.btn_enq_in = 1'b0;
        bus.btn_deq_in = 1'b0;
        bus.sw_data_in = 8'h00;

        repeat (3) @(negedge clock_10KHz);
        check("rst.enqueue", 32'(bus.enqueue_out), 32'd0);
        check("rst.dequeue", 32'(bus.dequeue_out), 32'd0);
        check_state("rst");
        reset = 1'b0;
        repeat (5) @(negedge clock_10KHz);

        do_op("deq_empty", 1'b0, 1'b1, 8'h00);
        do_op("enq_5a",    1'b1, 1'b0, 8'h5A);

`ifdef FILA_CTRL_DEBOUNCE_EN
        e0 = n_enq;
        for (int k = 0; k < 6; k++) begin
            bus.btn_enq_in = ~bus.btn_enq_in;
            repeat (2) @(negedge clock_10KHz);
        end
        bus.btn_enq_in = 1'b0;
        repeat (SETTLE) @(negedge clock_10KHz);
        check("bounce.no_pulse", 32'(n_enq - e0), 32'd0);
        do_op("bounce.stable", 1'b1, 1'b0, 8'h33);
`endif

        // Cycle-accurate capture on the first successful dequeue.
        e0 = n_enq;
        d0 = n_deq;
        bus.btn_deq_in = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clock_10KHz);
            if (bus.dequeue_out) begin
                found = 1'b1;
                break;
            end
        end
        check("tdeq.pulse_seen", 32'(found), 32'd1);
        repeat (2) @(negedge clock_10KHz);
        check("tdeq.c2_valid", 32'(bus.last_valid_out), 32'd0);
        @(negedge clock_10KHz);
        exp_last  = exp_q.pop_front();
        exp_valid = 1'b1;
        check("tdeq.c3_valid", 32'(bus.last_valid_out), 32'd1);
        check("tdeq.c3_last",  32'(bus.last_out),       32'(exp_last));
        bus.btn_deq_in = 1'b0;
        repeat (SETTLE) @(negedge clock_10KHz);
        check("tdeq.enq_pulses", 32'(n_enq - e0), 32'd0);
        check("tdeq.deq_pulses", 32'(n_deq - d0), 32'd1);
        check_state("tdeq");

        while (exp_q.size() < DEPTH) do_op("fill", 1'b1, 1'b0, 8'($urandom));
        do_op("enq_full",    1'b1, 1'b0, 8'($urandom));
        do_op("deq_clrfull", 1'b0, 1'b1, 8'h00);
        do_op("both_room",   1'b1, 1'b1, 8'($urandom));
        do_op("both_full",   1'b1, 1'b1, 8'($urandom));
        while (exp_q.size() > 0) do_op("drain", 1'b0, 1'b1, 8'h00);

        for (int i = 0; i < 10; i++) begin
            do_op($sformatf("alt%0d.enq", i), 1'b1, 1'b0, 8'(i));
            do_op($sformatf("alt%0d.deq", i), 1'b0, 1'b1, 8'h00);
        end

        for (int i = 0; i < 30; i++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r < 5)      do_op($sformatf("rnd%0d.enq", i),  1'b1, 1'b0, 8'($urandom));
            else if (r < 9) do_op($sformatf("rnd%0d.deq", i),  1'b0, 1'b1, 8'h00);
            else            do_op($sformatf("rnd%0d.both", i), 1'b1, 1'b1, 8'($urandom));
        end

        // Reset one cycle into the capture window.
        if (exp_q.size() == 0) do_op("pre_rst", 1'b1, 1'b0, 8'hC3);
        bus.btn_deq_in = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clock_10KHz);
            if (bus.dequeue_out) begin
                found = 1'b1;
                break;
            end
        end
        check("rcapt.pulse_seen", 32'(found), 32'd1);
        @(posedge clock_10KHz);
        #1 reset = 1'b1;
        #1;
        exp_q.delete();
        exp_data  = 8'h00;
        exp_last  = 8'h00;
        exp_valid = 1'b0;
        exp_full  = 1'b0;
        exp_empty = 1'b0;
        check("rcapt.enqueue", 32'(bus.enqueue_out), 32'd0);
        check("rcapt.dequeue", 32'(bus.dequeue_out), 32'd0);
        check_state("rcapt.now");
        bus.btn_deq_in = 1'b0;
        repeat (2) @(negedge clock_10KHz);
        reset = 1'b0;
        repeat (20) @(negedge clock_10KHz);
        check_state("rcapt.after");
        do_op("post_rst", 1'b1, 1'b0, 8'($urandom));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
